stopwatch_ctrl: RTL and testbench

- Control sequencer for the stopwatch datapath. Sits between the raw board inputs (pause button, reset button, adjust switch, field select) and the counter and display blocks.
- Conditions the buttons and runs the mode FSM (IDLE/RUN/PAUSE/ADJ).
- Issues single-cycle count-enable, clear and field-increment pulses to the counter, and the blink enable to the display.

---
 rtl/stopwatch_ctrl_if.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl_if
//  Description : Board-input / counter-control bundle for the stopwatch
//                control sequencer. The master drives the raw inputs and
//                ticks. The slave (stopwatch_ctrl) drives the control pulses
//                and the mode.
//  Revision    : 1.0  initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       btn_pause;
    logic       btn_reset;
    logic       adj_sw;
    logic       sel;
    logic       cnt_en;
    logic       cnt_clr;
    logic       inc_min;
    logic       inc_sec;
    logic       blink_en;
    logic [1:0] state;

    modport master (
        output tick_1hz, tick_2hz, btn_pause, btn_reset, adj_sw, sel,
        input  cnt_en, cnt_clr, inc_min, inc_sec, blink_en, state
    );

    modport slave (
        input  tick_1hz, tick_2hz, btn_pause, btn_reset, adj_sw, sel,
        output cnt_en, cnt_clr, inc_min, inc_sec, blink_en, state
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Stopwatch control sequencer. It synchronizes and debounces
//                the board inputs and runs the IDLE/RUN/PAUSE/ADJ mode FSM.
//                It issues registered single-cycle count, clear and
//                field-increment pulses, and the display blink enable.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire               clk,
    input  wire               rst,
    stopwatch_ctrl_if.slave   bus_if
);

    localparam int            c_CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_DB_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_ADJ   = 2'd3;

    // Bit map of the synchronizer vectors: 0 pause, 1 reset, 2 adjust, 3 select
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [1:0] btn_ev;

    logic       ev_pause;
    logic       ev_reset;
    logic       adj_s;
    logic       sel_s;

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q,   ret_d;
    logic       cnt_en_q,  cnt_en_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       inc_min_q, inc_min_d;
    logic       inc_sec_q, inc_sec_d;
    logic       blink_q,   blink_d;

    // Two-flop synchronizers for all asynchronous board inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus_if.sel, bus_if.adj_sw, bus_if.btn_reset, bus_if.btn_pause};
            sync2_q <= sync1_q;
        end
    end

    // One debouncer per button. The level flips only after the synchronized
    // input has disagreed for DEBOUNCE_CYCLES consecutive cycles. A flip to 1
    // is registered as the press event, so releases stay silent.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic [c_CW-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;
        logic            ev_q,  ev_d;

        // Count disagreement cycles, flip level at the threshold
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            ev_d  = 1'b0;
            if (sync2_q[gi] != lvl_q) begin
                if (cnt_q == c_DB_MAX) begin
                    lvl_d = ~lvl_q;
                    cnt_d = '0;
                    ev_d  = ~lvl_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end

        // Debouncer state and event register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
                ev_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
                ev_q  <= ev_d;
            end
        end

        assign btn_ev[gi] = ev_q;
    end

    assign ev_pause = btn_ev[0];
    assign ev_reset = btn_ev[1];
    assign adj_s    = sync2_q[2];
    assign sel_s    = sync2_q[3];

    // State register, return-state register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            ret_q     <= c_IDLE;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            inc_min_q <= 1'b0;
            inc_sec_q <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            inc_min_q <= inc_min_d;
            inc_sec_q <= inc_sec_d;
            blink_q   <= blink_d;
        end
    end

    // Next state: clear beats adjust entry/exit, which beats pause/run
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        if (ev_reset) begin
            state_d = c_IDLE;
            ret_d   = c_IDLE;
        end else if (adj_s && (state_q != c_ADJ)) begin
            ret_d   = state_q;
            state_d = c_ADJ;
        end else if (!adj_s && (state_q == c_ADJ)) begin
            state_d = ret_q;
        end else if (ev_pause) begin
            case (state_q)
                c_IDLE:  state_d = c_RUN;
                c_RUN:   state_d = c_PAUSE;
                c_PAUSE: state_d = c_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Output pulses are qualified by the current (old) state; a clear
    // suppresses every other pulse in the same cycle
    always_comb begin
        cnt_en_d  = bus_if.tick_1hz & (state_q == c_RUN) & ~ev_reset;
        inc_min_d = bus_if.tick_2hz & (state_q == c_ADJ) & ~sel_s & ~ev_reset;
        inc_sec_d = bus_if.tick_2hz & (state_q == c_ADJ) &  sel_s & ~ev_reset;
        cnt_clr_d = ev_reset;
        blink_d   = (state_d == c_ADJ);
    end

    assign bus_if.cnt_en   = cnt_en_q;
    assign bus_if.cnt_clr  = cnt_clr_q;
    assign bus_if.inc_min  = inc_min_q;
    assign bus_if.inc_sec  = inc_sec_q;
    assign bus_if.blink_en = blink_q;
    assign bus_if.state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed self-checking bench for stopwatch_ctrl
//                (DEBOUNCE_CYCLES = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Pulse / transition tallies, sampled mid-cycle
    int n_en    = 0;
    int n_min   = 0;
    int n_sec   = 0;
    int n_clr   = 0;
    int n_both  = 0;
    int n_trans = 0;
    logic [1:0] prev_state = 2'd0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (sw_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sw_if.cnt_en)                  n_en++;
        if (sw_if.inc_min)                 n_min++;
        if (sw_if.inc_sec)                 n_sec++;
        if (sw_if.cnt_clr)                 n_clr++;
        if (sw_if.inc_min && sw_if.inc_sec) n_both++;
        if (sw_if.state != prev_state)     n_trans++;
        prev_state = sw_if.state;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_pause(input int n);
        sw_if.btn_pause = 1'b1;
        repeat (n) step();
        sw_if.btn_pause = 1'b0;
        repeat (14) step();
    endtask

    task automatic tick1(input string tag, input logic exp);
        sw_if.tick_1hz = 1'b1;
        step();
        sw_if.tick_1hz = 1'b0;
        check(tag, 32'(sw_if.cnt_en), 32'(exp));
        step();
        check({tag, "_gone"}, 32'(sw_if.cnt_en), 32'd0);
    endtask

    task automatic tick2(input string tag, input logic exp_min, input logic exp_sec);
        sw_if.tick_2hz = 1'b1;
        step();
        sw_if.tick_2hz = 1'b0;
        check({tag, "_min"}, 32'(sw_if.inc_min), 32'(exp_min));
        check({tag, "_sec"}, 32'(sw_if.inc_sec), 32'(exp_sec));
        step();
    endtask

    initial begin
        int s_en, s_min, s_sec, s_clr, s_tr;
        sw_if.tick_1hz  = 1'b0;
        sw_if.tick_2hz  = 1'b0;
        sw_if.btn_pause = 1'b0;
        sw_if.btn_reset = 1'b0;
        sw_if.adj_sw    = 1'b0;
        sw_if.sel       = 1'b0;

        // 1. Reset then idle
        rst = 1'b1;
        repeat (3) step();
        check("rst_outs", 32'({sw_if.state, sw_if.cnt_en, sw_if.cnt_clr,
                               sw_if.inc_min, sw_if.inc_sec, sw_if.blink_en}), 32'd0);
        rst = 1'b0;
        step();
        s_en = n_en;
        for (int i = 0; i < 20; i++) tick1("idle_tick", 1'b0);
        check("idle_en_cnt", 32'(n_en - s_en), 32'd0);
        check("idle_state",  32'(sw_if.state), 32'd0);

        // 2. Run / pause
        s_tr = n_trans;
        press_pause(10);
        check("run_state", 32'(sw_if.state), 32'd1);
        check("run_trans", 32'(n_trans - s_tr), 32'd1);
        s_en = n_en;
        for (int i = 0; i < 5; i++) tick1("run_tick", 1'b1);
        check("run_en_cnt", 32'(n_en - s_en), 32'd5);
        press_pause(10);
        check("pause_state", 32'(sw_if.state), 32'd2);
        for (int i = 0; i < 3; i++) tick1("pause_tick", 1'b0);

        // 3. Bounce rejection, then a clean 6-cycle press
        s_tr = n_trans;
        for (int i = 0; i < 10; i++) begin
            sw_if.btn_pause = 1'b1;
            repeat (2) step();
            sw_if.btn_pause = 1'b0;
            step();
        end
        repeat (14) step();
        check("bounce_state", 32'(sw_if.state), 32'd2);
        check("bounce_trans", 32'(n_trans - s_tr), 32'd0);
        press_pause(6);
        check("clean_state", 32'(sw_if.state), 32'd1);
        check("clean_trans", 32'(n_trans - s_tr), 32'd1);
        press_pause(10);
        check("back_pause", 32'(sw_if.state), 32'd2);

        // 4. Adjust from PAUSE
        s_min = n_min; s_sec = n_sec; s_en = n_en;
        sw_if.adj_sw = 1'b1;
        repeat (4) step();
        check("adj_state", 32'(sw_if.state), 32'd3);
        check("adj_blink", 32'(sw_if.blink_en), 32'd1);
        for (int i = 0; i < 3; i++) tick2("adj_s0", 1'b1, 1'b0);
        sw_if.sel = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 2; i++) tick2("adj_s1", 1'b0, 1'b1);
        press_pause(10);
        check("adj_pause_ign", 32'(sw_if.state), 32'd3);
        tick1("adj_tick1", 1'b0);
        check("adj_min_cnt", 32'(n_min - s_min), 32'd3);
        check("adj_sec_cnt", 32'(n_sec - s_sec), 32'd2);
        check("adj_en_cnt",  32'(n_en - s_en),   32'd0);
        sw_if.adj_sw = 1'b0;
        sw_if.sel    = 1'b0;
        repeat (4) step();
        check("adj_exit_state", 32'(sw_if.state), 32'd2);
        check("adj_exit_blink", 32'(sw_if.blink_en), 32'd0);

        // 5. Adjust from RUN
        press_pause(10);
        check("run2_state", 32'(sw_if.state), 32'd1);
        sw_if.adj_sw = 1'b1;
        repeat (4) step();
        check("run_adj_state", 32'(sw_if.state), 32'd3);
        sw_if.adj_sw = 1'b0;
        repeat (4) step();
        check("run_ret_state", 32'(sw_if.state), 32'd1);
        tick1("resume_tick", 1'b1);

        // 6. Priority: reset + pause + tick together while in RUN
        s_clr = n_clr;
        sw_if.btn_pause = 1'b1;
        sw_if.btn_reset = 1'b1;
        repeat (6) step();
        sw_if.tick_1hz = 1'b1;
        step();
        sw_if.tick_1hz = 1'b0;
        check("prio_state", 32'(sw_if.state),   32'd0);
        check("prio_clr",   32'(sw_if.cnt_clr), 32'd1);
        check("prio_en",    32'(sw_if.cnt_en),  32'd0);
        step();
        check("prio_clr_gone", 32'(sw_if.cnt_clr), 32'd0);
        sw_if.btn_pause = 1'b0;
        sw_if.btn_reset = 1'b0;
        repeat (14) step();
        check("prio_clr_cnt", 32'(n_clr - s_clr), 32'd1);
        check("prio_final",   32'(sw_if.state),   32'd0);

        // Reset while in ADJ with the switch still on
        press_pause(10);
        sw_if.adj_sw = 1'b1;
        repeat (4) step();
        check("adjr_state", 32'(sw_if.state), 32'd3);
        sw_if.btn_reset = 1'b1;
        repeat (7) step();
        check("adjr_idle",  32'(sw_if.state),    32'd0);
        check("adjr_clr",   32'(sw_if.cnt_clr),  32'd1);
        check("adjr_blink0", 32'(sw_if.blink_en), 32'd0);
        step();
        check("adjr_back",  32'(sw_if.state),    32'd3);
        check("adjr_blink1", 32'(sw_if.blink_en), 32'd1);
        sw_if.btn_reset = 1'b0;
        repeat (14) step();
        sw_if.adj_sw = 1'b0;
        repeat (4) step();
        check("adjr_ret_idle", 32'(sw_if.state), 32'd0);

        // Asynchronous reset cuts a pulse mid-cycle
        press_pause(10);
        check("async_run", 32'(sw_if.state), 32'd1);
        sw_if.tick_1hz = 1'b1;
        step();
        sw_if.tick_1hz = 1'b0;
        check("async_pre", 32'(sw_if.cnt_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_en",    32'(sw_if.cnt_en), 32'd0);
        check("async_state", 32'(sw_if.state),  32'd0);
        #1 rst = 1'b0;
        step();

        check("never_both", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
